// File: rtl/data_sram_responder_pkg.sv
package data_sram_responder_pkg;

  localparam int unsigned WIDTH_HW_INT = 8;

  localparam logic [15:0] MMIO_TIMER = 16'h0000;
  localparam logic [15:0] MMIO_TCMP  = 16'h0004;
  localparam logic [15:0] MMIO_TCTRL = 16'h0008;
  localparam logic [15:0] MMIO_PEND  = 16'h000c;
  localparam logic [15:0] MMIO_SWINT = 16'h0010;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TIMER,
    REG_TCMP,
    REG_TCTRL,
    REG_PEND,
    REG_SWINT
  } mmio_reg_e;

  // Takes the word offset (addr[15:2]) so byte-offset bits never reach the compare.
  function automatic mmio_reg_e mmio_decode(input logic [13:0] word_off);
    mmio_reg_e sel;
    sel = REG_NONE;
    if (word_off == MMIO_TIMER[15:2]) sel = REG_TIMER;
    if (word_off == MMIO_TCMP[15:2])  sel = REG_TCMP;
    if (word_off == MMIO_TCTRL[15:2]) sel = REG_TCTRL;
    if (word_off == MMIO_PEND[15:2])  sel = REG_PEND;
    if (word_off == MMIO_SWINT[15:2]) sel = REG_SWINT;
    return sel;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  we);
    logic [31:0] mask;
    mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/data_sram_responder_sram_word_ram.sv
module sram_word_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    data_sram_en,
  input  logic [3:0]              data_sram_we,
  input  logic [31:0]             data_sram_addr,
  input  logic [31:0]             data_sram_wdata,
  output logic [31:0]             data_sram_rdata,
  output logic [WIDTH_HW_INT-1:0] hw_int
);

  logic        is_mmio;
  logic        ram_en;
  mmio_reg_e   reg_sel;
  logic [31:0] mmio_rd;
  logic        match;
  logic        unused_addr_bits;

  logic [31:0] ram_rdata;

  logic [31:0] timer_q, timer_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [1:0]  tctrl_q, tctrl_d;
  logic        pend_q, pend_d;
  logic [7:1]  swint_q, swint_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        ram_sel_q, ram_sel_d;
  logic [WIDTH_HW_INT-1:0] hw_int_q, hw_int_d;

  always_comb begin
    unused_addr_bits = ^data_sram_addr[1:0];
    is_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    ram_en  = data_sram_en & ~is_mmio;
    reg_sel = is_mmio ? mmio_decode(data_sram_addr[15:2]) : REG_NONE;
  end

  sram_word_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk   (clk),
    .resetn(resetn),
    .en    (ram_en),
    .we    (data_sram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    case (reg_sel)
      REG_TIMER: mmio_rd = timer_q;
      REG_TCMP:  mmio_rd = tcmp_q;
      REG_TCTRL: mmio_rd = {30'd0, tctrl_q};
      REG_PEND:  mmio_rd = {31'd0, pend_q};
      REG_SWINT: mmio_rd = {24'd0, swint_q, 1'b0};
      default:   mmio_rd = '0;
    endcase
  end

  // Bus write is applied on top of the increment/reload result, so unwritten
  // lanes still advance; PEND clear is applied before the match set.
  always_comb begin
    match   = tctrl_q[0] & (timer_q == tcmp_q);
    timer_d = timer_q;
    tcmp_d  = tcmp_q;
    tctrl_d = tctrl_q;
    pend_d  = pend_q;
    swint_d = swint_q;

    if (tctrl_q[0]) timer_d = (match & tctrl_q[1]) ? '0 : timer_q + 32'd1;

    if (data_sram_en) begin
      case (reg_sel)
        REG_TIMER: timer_d = byte_merge(timer_d, data_sram_wdata, data_sram_we);
        REG_TCMP:  tcmp_d  = byte_merge(tcmp_q, data_sram_wdata, data_sram_we);
        REG_TCTRL: if (data_sram_we[0]) tctrl_d = data_sram_wdata[1:0];
        REG_PEND:  if (data_sram_we[0] & data_sram_wdata[0]) pend_d = 1'b0;
        REG_SWINT: if (data_sram_we[0]) swint_d = data_sram_wdata[7:1];
        default: ;
      endcase
    end

    if (match) pend_d = 1'b1;
  end

  always_comb begin
    mmio_rdata_d = mmio_rdata_q;
    ram_sel_d    = ram_sel_q;
    if (data_sram_en) begin
      ram_sel_d = ~is_mmio;
      if (is_mmio) mmio_rdata_d = mmio_rd;
    end
    hw_int_d = {swint_q, pend_q};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q      <= '0;
      tcmp_q       <= '1;
      tctrl_q      <= '0;
      pend_q       <= 1'b0;
      swint_q      <= '0;
      mmio_rdata_q <= '0;
      ram_sel_q    <= 1'b0;
      hw_int_q     <= '0;
    end else begin
      timer_q      <= timer_d;
      tcmp_q       <= tcmp_d;
      tctrl_q      <= tctrl_d;
      pend_q       <= pend_d;
      swint_q      <= swint_d;
      mmio_rdata_q <= mmio_rdata_d;
      ram_sel_q    <= ram_sel_d;
      hw_int_q     <= hw_int_d;
    end
  end

  assign data_sram_rdata = ram_sel_q ? ram_rdata : mmio_rdata_q;
  assign hw_int          = hw_int_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam logic [31:0] MB = 32'hbfaf_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  hw;

  int total = 0;
  int bad = 0;

  data_sram_responder #(
    .RAM_AW(10),
    .MMIO_BASE(32'hbfaf_0000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_sram_en   (en),
    .data_sram_we   (we),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .hw_int         (hw)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_timer, m_tcmp, m_rdata;
  logic [1:0]  m_tctrl;
  logic        m_pend;
  logic [7:1]  m_swint;
  logic [7:0]  m_hw;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_timer = 0; m_tcmp = 32'hffff_ffff; m_tctrl = 0; m_pend = 0; m_swint = 0;
    m_rdata = 0; m_hw = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d);
    logic mm, hit;
    logic [15:0] off;
    int idx;
    logic [31:0] nt, old;
    mm  = (a[31:16] == 16'hbfaf);
    off = {a[15:2], 2'b00};
    idx = int'(a[11:2]);
    m_hw = {m_swint, m_pend};
    hit = m_tctrl[0] && (m_timer == m_tcmp);
    if (e) begin
      if (mm) begin
        case (off)
          16'h0000: m_rdata = m_timer;
          16'h0004: m_rdata = m_tcmp;
          16'h0008: m_rdata = {30'd0, m_tctrl};
          16'h000c: m_rdata = {31'd0, m_pend};
          16'h0010: m_rdata = {24'd0, m_swint, 1'b0};
          default:  m_rdata = 0;
        endcase
      end else begin
        m_rdata = m_mem.exists(idx) ? m_mem[idx] : 'x;
      end
    end
    nt = m_timer;
    if (m_tctrl[0]) nt = (hit && m_tctrl[1]) ? 32'd0 : m_timer + 1;
    if (e && mm) begin
      case (off)
        16'h0000: nt = lanes(nt, d, w);
        16'h0004: m_tcmp = lanes(m_tcmp, d, w);
        16'h0008: if (w[0]) m_tctrl = d[1:0];
        16'h000c: if (w[0] && d[0]) m_pend = 0;
        16'h0010: if (w[0]) m_swint = d[7:1];
        default: ;
      endcase
    end else if (e && w != 0) begin
      old = m_mem.exists(idx) ? m_mem[idx] : 'x;
      m_mem[idx] = lanes(old, d, w);
    end
    m_timer = nt;
    if (hit) m_pend = 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_step(e, w, a, d);
    #1;
  endtask

  task automatic do_reset();
    en = 0; we = 0;
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_hw", {24'd0, hw}, 32'h0);
    @(negedge clk);
    resetn = 1;
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
    logic [7:0]  exp_hw;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 4'hf, 32'h0000_1000, 32'hdeadbeef, 1'b0, 32'h0,         8'h00};
    tbl[1]  = '{1'b1, 4'h0, 32'h0000_1000, 32'h0,        1'b1, 32'hdeadbeef, 8'h00};
    tbl[2]  = '{1'b1, 4'h2, 32'h0000_1000, 32'h0000_5500, 1'b1, 32'hdeadbeef, 8'h00};
    tbl[3]  = '{1'b1, 4'h0, 32'h0000_1000, 32'h0,        1'b1, 32'hdead55ef, 8'h00};
    tbl[4]  = '{1'b1, 4'h0, MB | 32'h40,   32'h0,        1'b1, 32'h0,         8'h00};
    tbl[5]  = '{1'b1, 4'h1, MB | 32'h10,   32'hff,       1'b1, 32'h0,         8'h00};
    tbl[6]  = '{1'b1, 4'h0, MB | 32'h10,   32'h0,        1'b1, 32'hfe,        8'hfe};
    tbl[7]  = '{1'b1, 4'h1, MB | 32'h10,   32'h0,        1'b1, 32'hfe,        8'hfe};
    tbl[8]  = '{1'b1, 4'h0, MB | 32'h08,   32'h0,        1'b1, 32'h0,         8'h00};
    tbl[9]  = '{1'b1, 4'h0, MB | 32'h04,   32'h0,        1'b1, 32'hffff_ffff, 8'h00};
    tbl[10] = '{1'b1, 4'h0, MB | 32'h0c,   32'h0,        1'b1, 32'h0,         8'h00};
    tbl[11] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,        1'b1, 32'hdead55ef, 8'h00};
    tbl[12] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b1, 32'hdead55ef, 8'h00};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_hw", i), {24'd0, hw}, {24'd0, tbl[i].exp_hw});
    end

    // One-shot timer
    do_reset();
    step(1, 4'hf, MB | 32'h04, 32'd10);
    step(1, 4'hf, MB | 32'h08, 32'd1);
    for (int k = 0; k < 15; k++) begin
      step(0, 4'h0, 32'h0, 32'h0);
      check($sformatf("oneshot_hw_k%0d", k), {24'd0, hw}, (k >= 11) ? 32'd1 : 32'd0);
    end
    step(1, 4'h0, MB | 32'h00, 32'h0);
    check("oneshot_timer_past", rdata, 32'd15);

    // Periodic timer plus W1C collision
    do_reset();
    step(1, 4'hf, MB | 32'h04, 32'd3);
    step(1, 4'hf, MB | 32'h08, 32'd3);
    for (int k = 0; k < 5; k++) begin
      step(1, 4'h0, MB | 32'h00, 32'h0);
      check($sformatf("periodic_timer_k%0d", k), rdata, 32'(k % 4));
      check($sformatf("periodic_hw_k%0d", k), {24'd0, hw}, (k >= 4) ? 32'd1 : 32'd0);
    end
    step(1, 4'h1, MB | 32'h0c, 32'h1);
    check("w1c_rdata", rdata, 32'd1);
    step(1, 4'h0, MB | 32'h00, 32'h0);
    check("after_w1c_timer", rdata, 32'd2);
    check("after_w1c_hw", {24'd0, hw}, 32'd0);
    step(1, 4'h1, MB | 32'h0c, 32'h1);
    check("w1c_match_rdata", rdata, 32'd0);
    step(1, 4'h0, MB | 32'h0c, 32'h0);
    check("pend_set_wins", rdata, 32'd1);
    check("pend_set_wins_hw", {24'd0, hw}, 32'd1);

    // Timer write while counting
    do_reset();
    step(1, 4'hf, MB | 32'h08, 32'd1);
    repeat (3) step(0, 4'h0, 32'h0, 32'h0);
    step(1, 4'hf, MB | 32'h00, 32'h100);
    check("twrite_readfirst", rdata, 32'd3);
    step(1, 4'h0, MB | 32'h00, 32'h0);
    check("twrite_read0", rdata, 32'h100);
    step(1, 4'h0, MB | 32'h00, 32'h0);
    check("twrite_read1", rdata, 32'h101);

    // Asynchronous reset mid-read
    step(1, 4'h1, MB | 32'h10, 32'hff);
    step(1, 4'h0, 32'h0000_1000, 32'h0);
    check("prereset_rdata", rdata, 32'hdead55ef);
    check("prereset_hw", {24'd0, hw}, 32'hfe);
    en = 1; we = 0; addr = 32'h0000_1000;
    #2;
    resetn = 0;
    #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_hw", {24'd0, hw}, 32'h0);
    model_reset();
    @(negedge clk);
    en = 0;
    resetn = 1;
    step(0, 4'h0, 32'h0, 32'h0);
    check("postrst_hold", rdata, 32'h0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 4'hf, 32'(i) << 2, $urandom);
    step(1, 4'h0, 32'h0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      logic        e;
      logic [3:0]  w;
      logic [31:0] a, d;
      logic [15:0] up;
      logic [15:0] offs [7];
      offs = '{16'h0, 16'h4, 16'h8, 16'hc, 16'h10, 16'h14, 16'h40};
      e = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d = $urandom;
      if ($urandom_range(0, 9) < 4) begin
        a = MB | 32'(offs[$urandom_range(0, 6)]) | 32'($urandom_range(0, 3));
        if (a[15:2] == 14'h1) d = 32'($urandom_range(0, 40));
        if (a[15:2] == 14'h0 && d[0]) d = 32'($urandom_range(0, 30));
      end else begin
        up = 16'($urandom);
        if (up == 16'hbfaf) up = 16'h0;
        a = {up, 4'($urandom), 6'd0, 4'($urandom), 2'($urandom)};
      end
      step(e, w, a, d);
      if (!$isunknown(m_rdata)) check("rand_rdata", rdata, m_rdata);
      check("rand_hw", {24'd0, hw}, {24'd0, m_hw});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
